fib_uart_reporter: RTL

FIB_UART_REPORTER -- requirements
Module: fib_uart_reporter

---
 rtl/fib_uart_reporter_if.sv | 20 ++
 rtl/fib_uart_reporter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fib_uart_reporter_if.sv
// Producer/line bundle for fib_uart_reporter: 4-bit value handshake plus UART and status lines.
// The DUT uses the slave modport and the producer or bench uses the master modport.
interface fib_uart_reporter_if;
    logic       valid_in;
    logic [3:0] data_in;
    logic       ready_out;
    logic       tx_out;
    logic       busy_out;
    logic       overflow_out;

    modport master (
        output valid_in, data_in,
        input  ready_out, tx_out, busy_out, overflow_out
    );

    modport slave (
        input  valid_in, data_in,
        output ready_out, tx_out, busy_out, overflow_out
    );
endinterface

// File: rtl/fib_uart_reporter.sv
// Buffers 4-bit values in a small FIFO and sends each one as an uppercase ASCII hex char over UART 8N1.
// Optional macro FIB_UART_CRLF_EN appends CR and LF frames to every character.
module fib_uart_reporter #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clock_in,
    input  logic              reset_in,
    fib_uart_reporter_if.slave bus
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        logic [7:0] wide;
        wide = {4'h0, v};
        if (v < 4'd10) begin
            hex_ascii = wide + 8'h30;
        end else begin
            hex_ascii = wide + 8'h37;
        end
    endfunction

    logic [3:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_tx;
    logic              r_overflow;

    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_baud_wrap;
    logic              w_take_fifo;
    logic [7:0]        w_fifo_char;
    state_t            w_state_nxt;
    logic [BAUD_W-1:0] w_baud_nxt;
    logic [2:0]        w_bit_idx_nxt;
    logic [7:0]        w_shift_nxt;

`ifdef FIB_UART_CRLF_EN
    logic [1:0]        r_char_sel;
    logic [1:0]        w_char_sel_nxt;
`endif

    assign w_full        = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push        = bus.valid_in && !w_full;
    assign w_baud_wrap   = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_fifo_char   = hex_ascii(r_mem[r_rd_ptr]);

    assign bus.ready_out    = !w_full;
    assign bus.tx_out       = r_tx;
    assign bus.overflow_out = r_overflow;
    assign bus.busy_out     = (r_state != ST_IDLE) || (r_count != CNT_W'(0));

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clock_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
            r_count  <= CNT_W'(0);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Next-state logic; w_take_fifo marks the points where a new character may be loaded
    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = r_baud;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_pop         = 1'b0;
        w_take_fifo   = 1'b0;
`ifdef FIB_UART_CRLF_EN
        w_char_sel_nxt = r_char_sel;
`endif
        case (r_state)
            ST_IDLE: begin
                w_take_fifo = 1'b1;
            end
            ST_START: begin
                if (w_baud_wrap) begin
                    w_baud_nxt    = BAUD_W'(0);
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = ST_DATA;
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (w_baud_wrap) begin
                    w_baud_nxt = BAUD_W'(0);
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (w_baud_wrap) begin
                    w_baud_nxt = BAUD_W'(0);
`ifdef FIB_UART_CRLF_EN
                    if (r_char_sel == 2'd0) begin
                        w_shift_nxt    = 8'h0D;
                        w_char_sel_nxt = 2'd1;
                        w_state_nxt    = ST_START;
                    end else if (r_char_sel == 2'd1) begin
                        w_shift_nxt    = 8'h0A;
                        w_char_sel_nxt = 2'd2;
                        w_state_nxt    = ST_START;
                    end else begin
                        w_take_fifo = 1'b1;
                    end
`else
                    w_take_fifo = 1'b1;
`endif
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_take_fifo) begin
            w_baud_nxt = BAUD_W'(0);
`ifdef FIB_UART_CRLF_EN
            w_char_sel_nxt = 2'd0;
`endif
            if (r_count != CNT_W'(0)) begin
                w_pop       = 1'b1;
                w_shift_nxt = w_fifo_char;
                w_state_nxt = ST_START;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end else begin
            w_pop = 1'b0;
        end
    end

    // FSM and bit-timing registers
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state   <= ST_IDLE;
            r_baud    <= BAUD_W'(0);
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
`ifdef FIB_UART_CRLF_EN
            r_char_sel <= 2'd0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
`ifdef FIB_UART_CRLF_EN
            r_char_sel <= w_char_sel_nxt;
`endif
        end
    end

    // Serial line flop: follows the current state, so the start bit lands one edge after START is entered
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_tx <= 1'b1;
        end else begin
            case (r_state)
                ST_START: r_tx <= 1'b0;
                ST_DATA:  r_tx <= r_shift[r_bit_idx];
                default:  r_tx <= 1'b1;
            endcase
        end
    end

    // Sticky overflow on a value offered while full
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_overflow <= 1'b0;
        end else if (bus.valid_in && w_full) begin
            r_overflow <= 1'b1;
        end else begin
            r_overflow <= r_overflow;
        end
    end

endmodule
